// File: rtl/bin_bcd_7seg_seq.sv
// Sequential binary-to-BCD converter with 7-segment decode.
// Double dabble, one input bit per clock, MSB first. Results are loaded together
// with a single-cycle done pulse; outputs hold their previous values while busy.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - conversion request, sampled only when idle
//   bin_in  - unsigned binary value, latched when start is accepted
//   busy    - conversion in progress
//   done    - one-cycle pulse when bcd/seg/ovf update
//   ovf     - last result had bin_in >= 10^DIGITS
//   bcd     - packed BCD result, digit 0 (units) in bits [3:0]
//   seg     - packed segment patterns, digit 0 in bits [6:0], {g,f,e,d,c,b,a}
module bin_bcd_7seg_seq #(
  parameter int unsigned WIDTH          = 23,
  parameter int unsigned DIGITS         = 6,
  parameter bit          BLANK_LZ       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
  localparam logic [SEG_W-1:0] SEG_BLANK  = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [6:0]       PAT_DASH   = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic               acc_ovf_q, acc_ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, done_d, ovf_d;
  logic [BCD_W-1:0]   bcd_d;
  logic [SEG_W-1:0]   seg_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic               acc_carry;
  logic [SEG_W-1:0]   seg_new;
  logic               lead;
  logic [3:0]         digit;
  logic [6:0]         pat;

  // Active-high {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // Add-3 correction on every digit that is 5 or more, ahead of the shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is a dropped multiple of 10^DIGITS.
  assign acc_shift = {acc_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  assign acc_carry = acc_adj[BCD_W-1];

  // Segment image of the finished accumulator, scanning from the top digit so
  // leading zeros can be blanked until the first nonzero digit.
  always_comb begin
    seg_new = '0;
    lead    = 1'b1;
    digit   = '0;
    pat     = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      digit = acc_q[4*i +: 4];
      if (digit != 4'd0) lead = 1'b0;
      if (acc_ovf_q)                          pat = PAT_DASH;
      else if (BLANK_LZ && lead && (i != 0))  pat = 7'b0000000;
      else                                    pat = seg_decode(digit);
      seg_new[7*i +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    cnt_d     = cnt_q;
    busy_d    = busy;
    done_d    = 1'b0;
    ovf_d     = ovf;
    bcd_d     = bcd;
    seg_d     = seg;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          busy_d    = 1'b1;
          bin_d     = bin_in;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        bin_d     = bin_q << 1;
        acc_d     = acc_shift;
        acc_ovf_d = acc_ovf_q | acc_carry;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) state_d = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        bcd_d   = acc_q;
        seg_d   = seg_new;
        ovf_d   = acc_ovf_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      bcd       <= '0;
      seg       <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      ovf       <= ovf_d;
      bcd       <= bcd_d;
      seg       <= seg_d;
    end
  end

endmodule
